// File: rtl/local_inject_queue.sv
// local_inject_queue: injection FIFO between the local core and the router's
// local eject/inject stage. Flits are time-stamped on entry. The head flit is
// presented, registered, on inj_flit_o and is popped when the stage grants it.
// Optional feature macro: STARVE_DETECT_EN. When it is defined, a head that
// goes ungranted for too long raises starve_o and throttles new pushes.
// Field layout comes from global.vh. The defaults below apply only when that
// header has not already provided the macros.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TIME_WIDTH
`define TIME_WIDTH 4
`endif
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef TIME_POS
`define TIME_POS 30:27
`endif
`ifndef MAX_TIME
`define MAX_TIME ((1 << `TIME_WIDTH) - 1)
`endif

module local_inject_queue #(
  parameter int DATA_WIDTH    = `DATA_WIDTH,
  parameter int TIME_WIDTH    = `TIME_WIDTH,
  parameter int DEPTH         = 4,
  parameter int STARVE_THRESH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [DATA_WIDTH-1:0]    core_flit_i,
  input  logic                     core_valid_i,
  output logic                     core_ready_o,
  output logic [DATA_WIDTH-1:0]    inj_flit_o,
  input  logic                     inj_grant_i,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     starve_o
);

  localparam int AW = $clog2(DEPTH);
  // MAX_TIME is the local stage's "no flit" sentinel, so the counter stops one short
  localparam logic [TIME_WIDTH-1:0] LAST_TIME = TIME_WIDTH'(`MAX_TIME - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_THRESH < 1) begin : g_bad_param
    $error("local_inject_queue: DEPTH must be a power of 2 >= 2, STARVE_THRESH >= 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0]           cnt, cnt_nxt;
  logic [TIME_WIDTH-1:0] time_cnt;
  logic                  full, empty, push, pop, throttle;
  logic [DATA_WIDTH-1:0] stamped, head_nxt;

  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty        = (wr_ptr == rd_ptr);
  assign core_ready_o = !full && !throttle;
  assign push         = core_valid_i && core_ready_o;
  assign pop          = inj_grant_i && !empty;
  assign occupancy_o  = cnt;

  // Next pointers, count, stamped flit and the post-update head value
  always_comb begin
    stamped             = core_flit_i;
    stamped[`TIME_POS]  = time_cnt;
    wr_ptr_nxt          = push ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_nxt          = pop  ? rd_ptr + 1'b1 : rd_ptr;
    cnt_nxt             = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
    // The only entry not yet in mem is the one being pushed; when it lands
    // in the new head slot it must be forwarded straight to the output.
    head_nxt = '0;
    if (cnt_nxt != '0) begin
      if (push && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]))
        head_nxt = stamped;
      else
        head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  // Control state, timestamp counter and registered head flit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      time_cnt   <= '0;
      inj_flit_o <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      cnt        <= cnt_nxt;
      time_cnt   <= (time_cnt == LAST_TIME) ? '0 : time_cnt + 1'b1;
      inj_flit_o <= head_nxt;
    end
  end

  // Flit storage; contents are don't-care until the pointers cover them
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= stamped;
  end

`ifdef STARVE_DETECT_EN
  localparam int SW = $clog2(STARVE_THRESH) + 1;
  localparam logic [SW-1:0] THRESH = SW'(STARVE_THRESH);

  logic [SW-1:0] starve_cnt, starve_cnt_nxt;
  logic          starve_q;

  // Count consecutive ungranted cycles of a valid head, saturating at threshold
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (pop || empty)
      starve_cnt_nxt = '0;
    else if (!inj_grant_i && starve_cnt != THRESH)
      starve_cnt_nxt = starve_cnt + SW'(1);
  end

  // Starvation counter and registered flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      starve_cnt <= '0;
      starve_q   <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      starve_q   <= (starve_cnt_nxt == THRESH);
    end
  end

  assign starve_o = starve_q;
  assign throttle = starve_q;
`else
  assign starve_o = 1'b0;
  assign throttle = 1'b0;
`endif

endmodule

// File: tb/tb_local_inject_queue.sv
// Directed bench for local_inject_queue (DEPTH = 4, default field layout).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TIME_WIDTH
`define TIME_WIDTH 4
`endif
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef TIME_POS
`define TIME_POS 30:27
`endif
`ifndef MAX_TIME
`define MAX_TIME ((1 << `TIME_WIDTH) - 1)
`endif

module tb_local_inject_queue;
  localparam int DW    = `DATA_WIDTH;
  localparam int TW    = `TIME_WIDTH;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int TMOD  = `MAX_TIME;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [DW-1:0] core_flit_i = '0;
  logic          core_valid_i = 1'b0;
  logic          core_ready_o;
  logic [DW-1:0] inj_flit_o;
  logic          inj_grant_i = 1'b0;
  logic [OW-1:0] occupancy_o;
  logic          starve_o;

  int passed = 0;
  int total  = 0;
  int edges  = 0;
  logic [DW-1:0] exp_q [$];

  local_inject_queue #(.DEPTH(DEPTH), .STARVE_THRESH(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .core_flit_i(core_flit_i), .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .inj_flit_o(inj_flit_o), .inj_grant_i(inj_grant_i),
    .occupancy_o(occupancy_o), .starve_o(starve_o)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the timestamp of a push is this value mod MAX_TIME
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) edges <= 0;
    else        edges <= edges + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
    $fatal(1);
  end

  function automatic logic [DW-1:0] mk(input logic [7:0] pl);
    logic [DW-1:0] f;
    f = '0;
    f[`VALID_POS] = 1'b1;
    f[`TIME_POS]  = '1;
    f[15:8]       = ~pl;
    f[7:0]        = pl;
    return f;
  endfunction

  function automatic logic [DW-1:0] stamp(input logic [DW-1:0] f, input int t);
    logic [DW-1:0] s;
    s = f;
    s[`TIME_POS] = TW'(t);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; core_valid_i = 1'b0; inj_grant_i = 1'b0;
    #2;
    total++; if (inj_flit_o !== '0) $display("FAIL reset_flit: got %h required 0", inj_flit_o); else passed++;
    total++; if (occupancy_o !== '0) $display("FAIL reset_occ: got %0d required 0", occupancy_o); else passed++;
    total++; if (core_ready_o !== 1'b1) $display("FAIL reset_ready: got %b required 1", core_ready_o); else passed++;
    total++; if (starve_o !== 1'b0) $display("FAIL reset_starve: got %b required 0", starve_o); else passed++;
    @(negedge clk);
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_single_push();
    logic [DW-1:0] f, e;
    for (int i = 0; i < 20 && (edges % TMOD) != 3; i++) step();
    total++; if ((edges % TMOD) != 3) $display("FAIL single_wait: time=%0d required 3", edges % TMOD); else passed++;
    f = mk(8'hA5);
    e = stamp(f, 3);
    core_flit_i = f; core_valid_i = 1'b1;
    step();
    core_valid_i = 1'b0;
    total++; if (inj_flit_o !== e) $display("FAIL single_flit: got %h required %h", inj_flit_o, e); else passed++;
    total++; if (inj_flit_o[`VALID_POS] !== 1'b1) $display("FAIL single_valid: got %b required 1", inj_flit_o[`VALID_POS]); else passed++;
    total++; if (inj_flit_o[7:0] !== 8'hA5) $display("FAIL single_payload: got %h required a5", inj_flit_o[7:0]); else passed++;
    total++; if (inj_flit_o[`TIME_POS] !== TW'(3)) $display("FAIL single_time: got %0d required 3", inj_flit_o[`TIME_POS]); else passed++;
    total++; if (occupancy_o !== OW'(1)) $display("FAIL single_occ: got %0d required 1", occupancy_o); else passed++;
    inj_grant_i = 1'b1;
    step();
    inj_grant_i = 1'b0;
    total++; if (occupancy_o !== '0) $display("FAIL single_drain_occ: got %0d required 0", occupancy_o); else passed++;
    total++; if (inj_flit_o !== '0) $display("FAIL single_drain_flit: got %h required 0", inj_flit_o); else passed++;
  endtask

  task automatic test_fill();
    logic [DW-1:0] f;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      f = mk(8'(8'h10 + i));
      core_flit_i = f; core_valid_i = 1'b1;
      total++; if (core_ready_o !== 1'b1) $display("FAIL fill_ready_%0d: got %b required 1", i, core_ready_o); else passed++;
      exp_q.push_back(stamp(f, edges % TMOD));
      step();
    end
    core_flit_i = mk(8'h55);
    total++; if (core_ready_o !== 1'b0) $display("FAIL fill_full_ready: got %b required 0", core_ready_o); else passed++;
    total++; if (occupancy_o !== OW'(4)) $display("FAIL fill_occ: got %0d required 4", occupancy_o); else passed++;
    step();
    total++; if (occupancy_o !== OW'(4)) $display("FAIL fill_fifth_occ: got %0d required 4", occupancy_o); else passed++;
    total++; if (core_ready_o !== 1'b0) $display("FAIL fill_fifth_ready: got %b required 0", core_ready_o); else passed++;
    total++; if (inj_flit_o !== exp_q[0]) $display("FAIL fill_head: got %h required %h", inj_flit_o, exp_q[0]); else passed++;
  endtask

  task automatic test_full_pop();
    logic [DW-1:0] e;
    core_valid_i = 1'b1; inj_grant_i = 1'b1;
    step();
    core_valid_i = 1'b0;
    void'(exp_q.pop_front());
    total++; if (occupancy_o !== OW'(3)) $display("FAIL fullpop_occ: got %0d required 3", occupancy_o); else passed++;
    total++; if (core_ready_o !== 1'b1) $display("FAIL fullpop_ready: got %b required 1", core_ready_o); else passed++;
    total++; if (inj_flit_o !== exp_q[0]) $display("FAIL fullpop_head: got %h required %h", inj_flit_o, exp_q[0]); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      void'(exp_q.pop_front());
      e = (exp_q.size() > 0) ? exp_q[0] : '0;
      total++; if (inj_flit_o !== e) $display("FAIL drain_order_%0d: got %h required %h", i, inj_flit_o, e); else passed++;
      total++; if (occupancy_o !== OW'(exp_q.size())) $display("FAIL drain_occ_%0d: got %0d required %0d", i, occupancy_o, exp_q.size()); else passed++;
    end
    inj_grant_i = 1'b0;
  endtask

  task automatic test_empty_grant();
    inj_grant_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (occupancy_o !== '0) $display("FAIL empty_grant_occ_%0d: got %0d required 0", i, occupancy_o); else passed++;
      total++; if (inj_flit_o !== '0) $display("FAIL empty_grant_flit_%0d: got %h required 0", i, inj_flit_o); else passed++;
    end
    inj_grant_i = 1'b0;
  endtask

  task automatic test_time_wrap();
    logic [DW-1:0] fa, fb;
    int t;
    for (int i = 0; i < 2 * TMOD && (edges % TMOD) != TMOD - 1; i++) step();
    total++; if ((edges % TMOD) != TMOD - 1) $display("FAIL wrap_wait: time=%0d required %0d", edges % TMOD, TMOD - 1); else passed++;
    fa = mk(8'hC1);
    core_flit_i = fa; core_valid_i = 1'b1;
    step();
    total++; if (inj_flit_o[`TIME_POS] !== TW'(`MAX_TIME - 1)) $display("FAIL wrap_stamp_last: got %0d required %0d", inj_flit_o[`TIME_POS], `MAX_TIME - 1); else passed++;
    total++; if (inj_flit_o !== stamp(fa, `MAX_TIME - 1)) $display("FAIL wrap_flit_a: got %h required %h", inj_flit_o, stamp(fa, `MAX_TIME - 1)); else passed++;
    fb = mk(8'hC2);
    core_flit_i = fb; inj_grant_i = 1'b1;
    step();
    total++; if (inj_flit_o[`TIME_POS] !== TW'(0)) $display("FAIL wrap_stamp_zero: got %0d required 0", inj_flit_o[`TIME_POS]); else passed++;
    total++; if (inj_flit_o !== stamp(fb, 0)) $display("FAIL wrap_flit_b: got %h required %h", inj_flit_o, stamp(fb, 0)); else passed++;
    // Push and pop every cycle across a full counter period: head is always the newest flit
    for (int i = 0; i < (1 << TW); i++) begin
      core_flit_i = mk(8'(i));
      t = edges % TMOD;
      step();
      total++; if (inj_flit_o !== stamp(mk(8'(i)), t) || inj_flit_o[`TIME_POS] === TW'(`MAX_TIME))
        $display("FAIL wrap_sweep_%0d: got %h required %h", i, inj_flit_o, stamp(mk(8'(i)), t)); else passed++;
    end
    total++; if (occupancy_o !== OW'(1)) $display("FAIL wrap_sweep_occ: got %0d required 1", occupancy_o); else passed++;
    core_valid_i = 1'b0;
    step();
    inj_grant_i = 1'b0;
    total++; if (occupancy_o !== '0) $display("FAIL wrap_drain_occ: got %0d required 0", occupancy_o); else passed++;
  endtask

  task automatic test_starve();
    core_flit_i = mk(8'h77); core_valid_i = 1'b1;
    step();
    core_valid_i = 1'b0;
`ifdef STARVE_DETECT_EN
    repeat (7) step();
    total++; if (starve_o !== 1'b0) $display("FAIL starve_early: got %b required 0", starve_o); else passed++;
    total++; if (core_ready_o !== 1'b1) $display("FAIL starve_early_ready: got %b required 1", core_ready_o); else passed++;
    step();
    total++; if (starve_o !== 1'b1) $display("FAIL starve_set: got %b required 1", starve_o); else passed++;
    total++; if (core_ready_o !== 1'b0) $display("FAIL starve_throttle: got %b required 0", core_ready_o); else passed++;
    core_flit_i = mk(8'h78); core_valid_i = 1'b1;
    step();
    core_valid_i = 1'b0;
    total++; if (occupancy_o !== OW'(1)) $display("FAIL starve_push_blocked: got %0d required 1", occupancy_o); else passed++;
    inj_grant_i = 1'b1;
    step();
    inj_grant_i = 1'b0;
    total++; if (starve_o !== 1'b0) $display("FAIL starve_clear: got %b required 0", starve_o); else passed++;
    total++; if (occupancy_o !== '0) $display("FAIL starve_pop_occ: got %0d required 0", occupancy_o); else passed++;
`else
    repeat (10) step();
    total++; if (starve_o !== 1'b0) $display("FAIL starve_tied: got %b required 0", starve_o); else passed++;
    total++; if (core_ready_o !== 1'b1) $display("FAIL starve_ready: got %b required 1", core_ready_o); else passed++;
    total++; if (occupancy_o !== OW'(1)) $display("FAIL starve_occ: got %0d required 1", occupancy_o); else passed++;
    inj_grant_i = 1'b1;
    step();
    inj_grant_i = 1'b0;
    total++; if (occupancy_o !== '0) $display("FAIL starve_pop_occ: got %0d required 0", occupancy_o); else passed++;
`endif
  endtask

  task automatic test_async_reset();
    core_flit_i = mk(8'h31); core_valid_i = 1'b1;
    step();
    core_flit_i = mk(8'h32);
    step();
    core_valid_i = 1'b0;
    total++; if (occupancy_o !== OW'(2)) $display("FAIL arst_pre_occ: got %0d required 2", occupancy_o); else passed++;
    #2;
    n_rst = 1'b0;
    #1;
    total++; if (inj_flit_o !== '0) $display("FAIL arst_flit: got %h required 0", inj_flit_o); else passed++;
    total++; if (occupancy_o !== '0) $display("FAIL arst_occ: got %0d required 0", occupancy_o); else passed++;
    total++; if (core_ready_o !== 1'b1) $display("FAIL arst_ready: got %b required 1", core_ready_o); else passed++;
    total++; if (starve_o !== 1'b0) $display("FAIL arst_starve: got %b required 0", starve_o); else passed++;
    @(negedge clk);
    n_rst = 1'b1;
    step();
    total++; if (occupancy_o !== '0) $display("FAIL arst_post_occ: got %0d required 0", occupancy_o); else passed++;
    total++; if (inj_flit_o !== '0) $display("FAIL arst_post_flit: got %h required 0", inj_flit_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_full_pop();
    test_empty_grant();
    test_time_wrap();
    test_starve();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
